// File: rtl/lif_pkg.sv
`default_nettype none
// =============================================================================
// lif_pkg : shared state type, default sizes and saturating add for the
//           LIF sweep scheduler (optional refractory logic: LIF_REFRACTORY_EN)
// Revision: 1.0
// =============================================================================
package lif_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } lif_state_t;

   localparam int C_DEF_N          = 4;
   localparam int C_DEF_W          = 8;
   localparam int C_DEF_LEAK_SHIFT = 3;
   localparam int C_DEF_REF_TICKS  = 2;

   // Unsigned add clamped to the largest value representable in w bits.
   function automatic logic [31:0] sat_add(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int unsigned w);
      logic [32:0] sum;
      logic [32:0] lim;
      sum = {1'b0, a} + {1'b0, b};
      lim = (33'd1 << w) - 33'd1;
      return (sum > lim) ? lim[31:0] : sum[31:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/lif_update_unit.sv
`default_nettype none
// =============================================================================
// lif_update_unit : combinational leak/integrate/fire slot datapath
//                   (refractory ports exist only with LIF_REFRACTORY_EN)
// Revision: 1.0
// =============================================================================
module lif_update_unit
   import lif_pkg::*;
#(
   parameter int W          = C_DEF_W,
   parameter int LEAK_SHIFT = C_DEF_LEAK_SHIFT
`ifdef LIF_REFRACTORY_EN
   ,
   parameter int REF_TICKS  = C_DEF_REF_TICKS,
   parameter int RW         = 2
`endif
)
(
   input  logic [W-1:0]  v,
   input  logic [W-1:0]  acc,
   input  logic [W-1:0]  thresh,
`ifdef LIF_REFRACTORY_EN
   input  logic [RW-1:0] ref_cnt,
   output logic [RW-1:0] ref_next,
`endif
   output logic [W-1:0]  v_next,
   output logic          spike
);

   logic [W-1:0] w_leaked;
   logic [W-1:0] w_sum;
   logic         w_fire;

   assign w_leaked = v - (v >> LEAK_SHIFT);
   assign w_sum    = W'(sat_add(32'(w_leaked), 32'(acc), W));
   assign w_fire   = (w_sum >= thresh);

`ifdef LIF_REFRACTORY_EN
   // A refractory slot clears the membrane and drops the integrated input.
   always_comb begin
      v_next   = '0;
      ref_next = ref_cnt;
      spike    = 1'b0;
      if (ref_cnt != '0) begin
         ref_next = ref_cnt - RW'(1);
      end else if (w_fire) begin
         spike    = 1'b1;
         ref_next = RW'(REF_TICKS);
      end else begin
         v_next = w_sum;
      end
   end
`else
   assign v_next = w_fire ? '0 : w_sum;
   assign spike  = w_fire;
`endif

endmodule
`default_nettype wire

// File: rtl/lif_sweep_scheduler.sv
`default_nettype none
// =============================================================================
// lif_sweep_scheduler : time-multiplexed LIF neuron array controller, one
//                       neuron per cycle per tick (refractory: LIF_REFRACTORY_EN)
// Revision: 1.0
// =============================================================================
module lif_sweep_scheduler
   import lif_pkg::*;
#(
   parameter int N          = C_DEF_N,
   parameter int W          = C_DEF_W,
   parameter int LEAK_SHIFT = C_DEF_LEAK_SHIFT,
   parameter int REF_TICKS  = C_DEF_REF_TICKS
)
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ena,
   input  logic                 tick,
   input  logic                 syn_valid,
   input  logic [$clog2(N)-1:0] syn_idx,
   input  logic [W-1:0]         syn_w,
   input  logic [W-1:0]         thresh,
   output logic [N-1:0]         spike_out,
   output logic                 done,
   output logic                 busy,
   output logic                 overrun
);

   localparam int IW = $clog2(N);

   lif_state_t    r_state;
   logic [IW-1:0] r_idx;
   logic [W-1:0]  r_v   [N];
   logic [W-1:0]  r_acc [N];
   logic [N-1:0]  r_shadow;

   logic          w_tick;
   logic          w_syn;
   logic          w_sweep;
   logic [W-1:0]  w_v_next;
   logic          w_spike;
   logic [N-1:0]  w_shadow_next;

   assign w_tick  = tick & ena;
   assign w_syn   = syn_valid & ena;
   assign w_sweep = (r_state == SWEEP);

`ifdef LIF_REFRACTORY_EN
   localparam int RW = (REF_TICKS > 0) ? $clog2(REF_TICKS + 1) : 1;

   logic [RW-1:0] r_ref [N];
   logic [RW-1:0] w_ref_next;

   lif_update_unit #(
      .W          (W),
      .LEAK_SHIFT (LEAK_SHIFT),
      .REF_TICKS  (REF_TICKS),
      .RW         (RW)
   ) u_update (
      .v        (r_v[r_idx]),
      .acc      (r_acc[r_idx]),
      .thresh   (thresh),
      .ref_cnt  (r_ref[r_idx]),
      .ref_next (w_ref_next),
      .v_next   (w_v_next),
      .spike    (w_spike)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) r_ref[i] <= '0;
      end else if (w_sweep) begin
         r_ref[r_idx] <= w_ref_next;
      end
   end
`else
   lif_update_unit #(
      .W          (W),
      .LEAK_SHIFT (LEAK_SHIFT)
   ) u_update (
      .v        (r_v[r_idx]),
      .acc      (r_acc[r_idx]),
      .thresh   (thresh),
      .v_next   (w_v_next),
      .spike    (w_spike)
   );
`endif

   always_comb begin
      w_shadow_next        = r_shadow;
      w_shadow_next[r_idx] = w_spike;
   end

   // An event hitting the neuron under update replaces the consumed value,
   // so it lands in the next timestep instead of being lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            r_v[i]   <= '0;
            r_acc[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (w_sweep && (r_idx == IW'(i))) begin
               r_v[i]   <= w_v_next;
               r_acc[i] <= (w_syn && (syn_idx == IW'(i))) ? syn_w : '0;
            end else if (w_syn && (syn_idx == IW'(i))) begin
               r_acc[i] <= W'(sat_add(32'(r_acc[i]), 32'(syn_w), W));
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_idx     <= '0;
         r_shadow  <= '0;
         spike_out <= '0;
         done      <= 1'b0;
         busy      <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_tick) begin
                  r_state <= SWEEP;
                  r_idx   <= '0;
                  busy    <= 1'b1;
               end
            end
            SWEEP: begin
               if (w_tick) overrun <= 1'b1;
               r_shadow <= w_shadow_next;
               r_idx    <= r_idx + IW'(1);
               if (r_idx == IW'(N - 1)) begin
                  r_state   <= IDLE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  spike_out <= w_shadow_next;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_lif_sweep_scheduler.sv
`default_nettype none
// =============================================================================
// tb_lif_sweep_scheduler : directed bench with a spike-vector scoreboard fed
//                          by a behavioural LIF model (tracks LIF_REFRACTORY_EN)
// Revision: 1.0
// =============================================================================
module tb_lif_sweep_scheduler;

   localparam int N          = 4;
   localparam int W          = 8;
   localparam int LEAK_SHIFT = 3;
   localparam int REF_TICKS  = 2;
   localparam int VMAX       = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         ena = 1'b0;
   logic         tick = 1'b0;
   logic         syn_valid = 1'b0;
   logic [1:0]   syn_idx = '0;
   logic [W-1:0] syn_w = '0;
   logic [W-1:0] thresh = 8'd100;
   logic [N-1:0] spike_out;
   logic         done;
   logic         busy;
   logic         overrun;

   lif_sweep_scheduler #(
      .N          (N),
      .W          (W),
      .LEAK_SHIFT (LEAK_SHIFT),
      .REF_TICKS  (REF_TICKS)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .tick      (tick),
      .syn_valid (syn_valid),
      .syn_idx   (syn_idx),
      .syn_w     (syn_w),
      .thresh    (thresh),
      .spike_out (spike_out),
      .done      (done),
      .busy      (busy),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;
   logic [N-1:0] sb_q [$];
   int m_v   [N];
   int m_acc [N];
   int m_ref [N];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_v[i] = 0; m_acc[i] = 0; m_ref[i] = 0;
      end
   endtask

   // Whole-timestep reference update; result goes onto the scoreboard.
   task automatic model_step(input int thr);
      logic [N-1:0] s_vec;
      s_vec = '0;
      for (int i = 0; i < N; i++) begin
         int s;
`ifdef LIF_REFRACTORY_EN
         if (m_ref[i] > 0) begin
            m_ref[i]--; m_v[i] = 0; m_acc[i] = 0;
            continue;
         end
`endif
         s = m_v[i] - (m_v[i] >> LEAK_SHIFT) + m_acc[i];
         if (s > VMAX) s = VMAX;
         m_acc[i] = 0;
         if (s >= thr) begin
            s_vec[i] = 1'b1; m_v[i] = 0; m_ref[i] = REF_TICKS;
         end else begin
            m_v[i] = s;
         end
      end
      sb_q.push_back(s_vec);
   endtask

   task automatic model_add(input int idx, input int w);
      m_acc[idx] = (m_acc[idx] + w > VMAX) ? VMAX : m_acc[idx] + w;
   endtask

   task automatic send_ev(input int idx, input int w);
      syn_valid = 1'b1; ena = 1'b1;
      syn_idx = idx[1:0]; syn_w = w[W-1:0];
      model_add(idx, w);
      @(negedge clk);
      syn_valid = 1'b0;
   endtask

   // ev_slot >= 0 drives an event to that neuron during its own slot;
   // dbl re-asserts tick while the sweep is busy.
   task automatic run_tick(input string tag, input int ev_slot, input int ev_w, input bit dbl);
      int bcnt;
      bit seen;
      logic [N-1:0] exp;
      bcnt = 0; seen = 1'b0;
      tick = 1'b1; ena = 1'b1;
      model_step(int'(thresh));
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         tick = dbl && (c == 0);
         syn_valid = (c == ev_slot);
         if (c == ev_slot) begin
            syn_idx = ev_slot[1:0]; syn_w = ev_w[W-1:0];
            model_add(ev_slot, ev_w);
         end
         if (busy) bcnt++;
         if (done) seen = 1'b1;
      end
      tick = 1'b0; syn_valid = 1'b0;
      check({tag, "_done"}, 32'(seen), 32'd1);
      check({tag, "_busy_cycles"}, 32'(bcnt), 32'(N));
      exp = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
      check({tag, "_spike"}, 32'(spike_out), 32'(exp));
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      bit saw_done;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_spike", 32'(spike_out), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_tick("idle", -1, 0, 1'b0);
      send_ev(0, 60);  run_tick("n0_60", -1, 0, 1'b0);
      send_ev(0, 50);  run_tick("n0_103", -1, 0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         send_ev(0, 200); run_tick("n0_post", -1, 0, 1'b0);
      end
      send_ev(2, 200); send_ev(2, 200); run_tick("n2_sat", -1, 0, 1'b0);
      thresh = 8'd0;   run_tick("thr0", -1, 0, 1'b0);
      thresh = 8'd100;
      run_tick("settle", -1, 0, 1'b0);
      run_tick("settle", -1, 0, 1'b0);
      run_tick("slot_ev", 1, 150, 1'b0);
      run_tick("slot_ev_next", -1, 0, 1'b0);

      ena = 1'b0; tick = 1'b1;
      @(negedge clk); tick = 1'b0;
      @(negedge clk);
      check("ena_low_busy", 32'(busy), 32'd0);

      check("pre_overrun", 32'(overrun), 32'd0);
      run_tick("ovr", -1, 0, 1'b1);
      check("overrun_set", 32'(overrun), 32'd1);
      thresh = 8'd0;
      run_tick("ovr_sticky", -1, 0, 1'b0);
      check("overrun_sticky", 32'(overrun), 32'd1);
      thresh = 8'd100;

      tick = 1'b1; ena = 1'b1;
      @(negedge clk); tick = 1'b0;
      @(negedge clk);
      check("mid_busy", 32'(busy), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_spike", 32'(spike_out), 32'd0);
      check("mid_rst_overrun", 32'(overrun), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      model_reset();
      @(negedge clk); rst_n = 1'b1;
      saw_done = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (done || busy) saw_done = 1'b1;
      end
      check("mid_rst_no_done", 32'(saw_done), 32'd0);
      check("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
`default_nettype wire
